// File: rtl/reg_slice_pkg.sv
// Shared definitions for the register-slice family: occupancy width helper
// and depth legality check used at elaboration.
package reg_slice_pkg;

  localparam int unsigned MIN_DEPTH = 32'd1;

  function automatic int unsigned occ_width(input int unsigned depth);
    return $clog2(depth + 32'd1);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= MIN_DEPTH);
  endfunction

endpackage

// File: rtl/reg_slice_forward.sv
// One forward register-slice stage: valid and payload are registered, ready
// is combinational (empty or draining).
module reg_slice_forward #(
  parameter int unsigned PLD_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [PLD_WIDTH-1:0] s_pld,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [PLD_WIDTH-1:0] m_pld
);

  logic                 vld_q;
  logic                 vld_d;
  logic [PLD_WIDTH-1:0] pld_q;
  logic [PLD_WIDTH-1:0] pld_d;
  logic                 rdy_s;
  logic                 load_s;

  // Next-state: flush clears, load captures, drain empties, otherwise hold.
  always_comb begin
    rdy_s  = !vld_q || m_rdy;
    load_s = s_vld && rdy_s;
    vld_d  = vld_q;
    pld_d  = pld_q;
    if (flush) begin
      vld_d = 1'b0;
    end else if (load_s) begin
      vld_d = 1'b1;
      pld_d = s_pld;
    end else if (m_rdy) begin
      vld_d = 1'b0;
    end else begin
      vld_d = vld_q;
    end
  end

  // Stage registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      pld_q <= {PLD_WIDTH{1'b0}};
    end else begin
      vld_q <= vld_d;
      pld_q <= pld_d;
    end
  end

  assign s_rdy = rdy_s;
  assign m_vld = vld_q;
  assign m_pld = pld_q;

endmodule

// File: rtl/reg_slice_occ_chk.sv
// Occupancy bound checker for reg_slice_forward_pipe; bound only when the
// REG_SLICE_FWD_OCC_EN counter exists.
module reg_slice_occ_chk #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned OCC_W = 2
) (
  input logic             clk,
  input logic             rst_n,
  input logic [OCC_W-1:0] occ
);

  // The counter must never report more beats than there are stages.
  a_occ_bound : assert property (@(posedge clk) disable iff (!rst_n)
                                 (int'(occ) <= int'(DEPTH)))
    else $error("occ exceeds DEPTH");

endmodule

// File: rtl/reg_slice_forward_pipe.sv
// DEPTH-stage forward register slice: breaks the valid/payload path, keeps
// ready combinational. Optional occupancy port via REG_SLICE_FWD_OCC_EN.
module reg_slice_forward_pipe
  import reg_slice_pkg::*;
#(
  parameter int unsigned PLD_WIDTH = 32,
  parameter int unsigned DEPTH     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 s_vld,
  output logic                 s_rdy,
  input  logic [PLD_WIDTH-1:0] s_pld,
  output logic                 m_vld,
  input  logic                 m_rdy,
  output logic [PLD_WIDTH-1:0] m_pld
`ifdef REG_SLICE_FWD_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occ
`endif
);

  if (!depth_ok(DEPTH)) begin : g_bad_depth
    $error("reg_slice_forward_pipe: DEPTH must be at least 1");
  end

  // Stage 0 faces upstream; stage DEPTH-1 drives the outputs directly.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic                 in_vld_s;
    logic [PLD_WIDTH-1:0] in_pld_s;
    logic                 out_rdy_s;
    logic                 vld_s;
    logic                 rdy_s;
    logic [PLD_WIDTH-1:0] pld_s;

    if (k == 0) begin : g_first
      assign in_vld_s = s_vld && !flush;
      assign in_pld_s = s_pld;
    end else begin : g_inner
      assign in_vld_s = g_stage[k-1].vld_s;
      assign in_pld_s = g_stage[k-1].pld_s;
    end

    if (k == DEPTH - 1) begin : g_last
      assign out_rdy_s = m_rdy;
    end else begin : g_chain
      assign out_rdy_s = g_stage[k+1].rdy_s;
    end

    reg_slice_forward #(
      .PLD_WIDTH (PLD_WIDTH)
    ) u_stage (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (flush),
      .s_vld (in_vld_s),
      .s_rdy (rdy_s),
      .s_pld (in_pld_s),
      .m_vld (vld_s),
      .m_rdy (out_rdy_s),
      .m_pld (pld_s)
    );
  end

  // Flush blocks both handshakes in the cycle it is asserted.
  assign s_rdy = g_stage[0].rdy_s && !flush;
  assign m_vld = g_stage[DEPTH-1].vld_s && !flush;
  assign m_pld = g_stage[DEPTH-1].pld_s;

`ifdef REG_SLICE_FWD_OCC_EN
  localparam int unsigned OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_q;
  logic [OCC_W-1:0] occ_d;
  logic             accept_s;
  logic             drain_s;

  // Occupancy tracks external handshakes; both or neither leaves it unchanged.
  always_comb begin
    accept_s = s_vld && s_rdy;
    drain_s  = m_vld && m_rdy;
    occ_d    = occ_q;
    if (flush) begin
      occ_d = {OCC_W{1'b0}};
    end else begin
      case ({accept_s, drain_s})
        2'b10:   occ_d = occ_q + OCC_W'(1'b1);
        2'b01:   occ_d = occ_q - OCC_W'(1'b1);
        default: occ_d = occ_q;
      endcase
    end
  end

  // Occupancy register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      occ_q <= {OCC_W{1'b0}};
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;

  reg_slice_occ_chk #(
    .DEPTH (DEPTH),
    .OCC_W (OCC_W)
  ) u_occ_chk (
    .clk   (clk),
    .rst_n (rst_n),
    .occ   (occ_q)
  );
`endif

endmodule
